// File: rtl/sta_mirror_arb.sv
// Write/read scheduler for the link status mirror RAM: post-reset clear, round-robin
// write-port sharing among status requesters, and host reads with optional clear-on-read.
module sta_mirror_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ-1:0]            req_merge,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          host_rd_req,
  output logic                          host_rd_rdy,
  input  logic [ADDR_WIDTH-1:0]         host_rd_addr,
  input  logic                          host_rd_clr,
  output logic                          host_rd_vld,
  output logic [DATA_WIDTH-1:0]         host_rd_data,
  output logic                          init_done,
  output logic                          ram_wr_en,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
  output logic [DATA_WIDTH-1:0]         ram_wr_data,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {INIT, RUN} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    init_done_q;
  logic                    host_rd_vld_q;
  logic [DATA_WIDTH-1:0]   host_rd_data_q;

  logic                    run, host_acc, host_clr, gnt_found;
  logic [PTR_W-1:0]        gnt_idx, cand;
  logic [NUM_REQ-1:0]      elig;
  logic [ADDR_WIDTH-1:0]   addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]   data_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign run         = (state_q == RUN);
  assign host_rd_rdy = run;
  assign host_rd_vld = host_rd_vld_q;
  assign host_rd_data = host_rd_data_q;
  assign init_done   = init_done_q;

  // Merge requesters need the read port, so they yield to any host read this cycle.
  always_comb begin
    host_acc  = run && host_rd_req;
    host_clr  = host_acc && host_rd_clr;
    elig      = '0;
    if (run && !host_clr)
      elig = req_vld & (~req_merge | {NUM_REQ{!host_acc}});
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + int'(k)) % NUM_REQ);
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    req_rdy = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      req_rdy[i] = gnt_found && (gnt_idx == PTR_W'(i));
    ptr_d = ptr_q;
    if (gnt_found)
      ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    ram_rd_addr = addr_a[gnt_idx];
    if (host_acc)
      ram_rd_addr = host_rd_addr;
  end

  // Kept apart from the grant logic: write data depends on the RAM's async read of ram_rd_addr.
  always_comb begin
    ram_wr_en   = 1'b0;
    ram_wr_addr = addr_a[gnt_idx];
    ram_wr_data = '0;
    if (!run) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = cnt_q;
    end else if (host_clr) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = host_rd_addr;
    end else if (gnt_found) begin
      ram_wr_en   = 1'b1;
      ram_wr_data = req_merge[gnt_idx] ? (ram_rd_data | data_a[gnt_idx]) : data_a[gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= INIT;
      cnt_q          <= '0;
      ptr_q          <= '0;
      init_done_q    <= 1'b0;
      host_rd_vld_q  <= 1'b0;
      host_rd_data_q <= '0;
    end else begin
      host_rd_vld_q <= host_acc;
      if (host_acc)
        host_rd_data_q <= ram_rd_data;
      ptr_q <= ptr_d;
      if (state_q == INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sta_mirror_arb.sv
// Directed self-checking bench for sta_mirror_arb with a behavioural async-read RAM.
module tb_sta_mirror_arb;

  logic        clk, rst_n;
  logic [3:0]  req_vld, req_rdy, req_merge;
  logic [3:0]  ra [4];
  logic [63:0] rd [4];
  logic [15:0] req_addr;
  logic [255:0] req_data;
  logic        host_rd_req, host_rd_rdy, host_rd_clr, host_rd_vld, init_done;
  logic [3:0]  host_rd_addr, ram_wr_addr, ram_rd_addr;
  logic [63:0] host_rd_data, ram_wr_data, ram_rd_data;
  logic        ram_wr_en;
  logic [63:0] mem [16];

  int checks = 0;
  int failures = 0;

  assign req_addr = {ra[3], ra[2], ra[1], ra[0]};
  assign req_data = {rd[3], rd[2], rd[1], rd[0]};

  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  sta_mirror_arb #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_merge(req_merge),
    .req_addr(req_addr), .req_data(req_data),
    .host_rd_req(host_rd_req), .host_rd_rdy(host_rd_rdy), .host_rd_addr(host_rd_addr),
    .host_rd_clr(host_rd_clr), .host_rd_vld(host_rd_vld), .host_rd_data(host_rd_data),
    .init_done(init_done),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] i, input logic v, input logic m,
                         input logic [3:0] a, input logic [63:0] d);
    req_vld[i] = v; req_merge[i] = m; ra[i] = a; rd[i] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) set_req(2'(i), 1'b0, 1'b0, 4'h0, 64'h0);
  endtask

  task automatic host_read(input logic [3:0] a, input logic clr, output logic v, output logic [63:0] d);
    host_rd_req = 1'b1; host_rd_addr = a; host_rd_clr = clr;
    tick();
    host_rd_req = 1'b0; host_rd_clr = 1'b0;
    v = host_rd_vld; d = host_rd_data;
  endtask

  task automatic run_init(input string tag);
    for (int c = 0; c < 16; c++) begin
      checks++;
      if ({ram_wr_en, ram_wr_addr, ram_wr_data, init_done, req_rdy} !== {1'b1, 4'(c), 64'h0, 1'b0, 4'h0}) begin
        failures++;
        $display("FAIL %s_init%0d: wr_en=%b addr=%0h data=%0h done=%b rdy=%b expected 1/%0h/0/0/0",
                 tag, c, ram_wr_en, ram_wr_addr, ram_wr_data, init_done, req_rdy, c);
      end
      tick();
    end
    checks++;
    if ({init_done, host_rd_rdy} !== 2'b11) begin
      failures++;
      $display("FAIL %s_done: init_done=%b host_rd_rdy=%b expected 1 1", tag, init_done, host_rd_rdy);
    end
  endtask

  task automatic test_reset();
    logic v; logic [63:0] d;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_rdy, host_rd_rdy, host_rd_vld, host_rd_data, init_done, ram_wr_en} !== {4'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_vals: rdy=%b hrdy=%b hvld=%b hdata=%0h done=%b wr_en=%b expected 0 0 0 0 0 1",
               req_rdy, host_rd_rdy, host_rd_vld, host_rd_data, init_done, ram_wr_en);
    end
    rst_n = 1'b1;
    run_init("rst");
    host_read(4'd5, 1'b0, v, d);
    checks++;
    if ({v, d} !== {1'b1, 64'h0}) begin
      failures++; $display("FAIL init_read5: vld=%b data=%0h expected 1 0", v, d);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    logic v; logic [63:0] d;
    for (int i = 0; i < 4; i++) set_req(2'(i), 1'b1, 1'b0, 4'(i), 64'(i + 1) * 64'h11);
    exp = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({req_rdy, ram_wr_en} !== {exp, 1'b1}) begin
        failures++; $display("FAIL rr_grant%0d: req_rdy=%b wr_en=%b expected %b 1", c, req_rdy, ram_wr_en, exp);
      end
      tick();
      exp = {exp[2:0], exp[3]};
    end
    clear_reqs();
    for (int a = 0; a < 4; a++) begin
      host_read(4'(a), 1'b0, v, d);
      checks++;
      if ({v, d} !== {1'b1, 64'(a + 1) * 64'h11}) begin
        failures++; $display("FAIL rr_data%0d: vld=%b data=%0h expected 1 %0h", a, v, d, 64'(a + 1) * 64'h11);
      end
    end
  endtask

  task automatic test_merge();
    logic v; logic [63:0] d;
    set_req(2'd2, 1'b1, 1'b0, 4'd3, 64'h0F);
    #1;
    checks++;
    if (req_rdy !== 4'b0100) begin failures++; $display("FAIL merge_pre_gnt: req_rdy=%b expected 0100", req_rdy); end
    tick();
    clear_reqs();
    set_req(2'd3, 1'b1, 1'b1, 4'd3, 64'hF0);
    #1;
    checks++;
    if ({req_rdy, ram_wr_data} !== {4'b1000, 64'hFF}) begin
      failures++; $display("FAIL merge_wdata: req_rdy=%b wr_data=%0h expected 1000 ff", req_rdy, ram_wr_data);
    end
    tick();
    clear_reqs();
    host_read(4'd3, 1'b0, v, d);
    checks++;
    if ({v, d} !== {1'b1, 64'hFF}) begin failures++; $display("FAIL merge_read3: vld=%b data=%0h expected 1 ff", v, d); end
    // merge held off by a concurrent host read, granted once the read port frees
    set_req(2'd1, 1'b1, 1'b1, 4'd4, 64'h5);
    host_rd_req = 1'b1; host_rd_addr = 4'd0;
    #1;
    checks++;
    if (req_rdy !== 4'b0000) begin failures++; $display("FAIL merge_blocked: req_rdy=%b expected 0000", req_rdy); end
    tick();
    host_rd_req = 1'b0;
    #1;
    checks++;
    if ({host_rd_vld, host_rd_data, req_rdy} !== {1'b1, 64'h11, 4'b0010}) begin
      failures++; $display("FAIL merge_unblock: hvld=%b hdata=%0h rdy=%b expected 1 11 0010", host_rd_vld, host_rd_data, req_rdy);
    end
    tick();
    clear_reqs();
    host_read(4'd4, 1'b0, v, d);
    checks++;
    if ({v, d} !== {1'b1, 64'h5}) begin failures++; $display("FAIL merge_read4: vld=%b data=%0h expected 1 5", v, d); end
  endtask

  task automatic test_clear_on_read();
    logic v; logic [63:0] d;
    set_req(2'd1, 1'b1, 1'b0, 4'd9, 64'h99);
    host_rd_req = 1'b1; host_rd_addr = 4'd2; host_rd_clr = 1'b1;
    #1;
    checks++;
    if ({req_rdy, ram_wr_en, ram_wr_addr, ram_wr_data} !== {4'b0000, 1'b1, 4'd2, 64'h0}) begin
      failures++; $display("FAIL clr_write: rdy=%b wr_en=%b addr=%0h data=%0h expected 0000 1 2 0",
                           req_rdy, ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    tick();
    host_rd_req = 1'b0; host_rd_clr = 1'b0;
    #1;
    checks++;
    if ({host_rd_vld, host_rd_data, req_rdy} !== {1'b1, 64'h33, 4'b0010}) begin
      failures++; $display("FAIL clr_old_next: hvld=%b hdata=%0h rdy=%b expected 1 33 0010", host_rd_vld, host_rd_data, req_rdy);
    end
    tick();
    clear_reqs();
    host_read(4'd2, 1'b0, v, d);
    checks++;
    if ({v, d} !== {1'b1, 64'h0}) begin failures++; $display("FAIL clr_read2: vld=%b data=%0h expected 1 0", v, d); end
    host_read(4'd9, 1'b0, v, d);
    checks++;
    if ({v, d} !== {1'b1, 64'h99}) begin failures++; $display("FAIL clr_read9: vld=%b data=%0h expected 1 99", v, d); end
  endtask

  task automatic test_read_during_write();
    logic v; logic [63:0] d;
    set_req(2'd0, 1'b1, 1'b0, 4'd7, 64'h77);
    tick();
    set_req(2'd0, 1'b1, 1'b0, 4'd7, 64'hAA);
    host_rd_req = 1'b1; host_rd_addr = 4'd7;
    #1;
    checks++;
    if (req_rdy !== 4'b0001) begin failures++; $display("FAIL rdw_grant: req_rdy=%b expected 0001", req_rdy); end
    tick();
    host_rd_req = 1'b0;
    clear_reqs();
    checks++;
    if ({host_rd_vld, host_rd_data} !== {1'b1, 64'h77}) begin
      failures++; $display("FAIL rdw_old: hvld=%b hdata=%0h expected 1 77", host_rd_vld, host_rd_data);
    end
    host_read(4'd7, 1'b0, v, d);
    checks++;
    if ({v, d} !== {1'b1, 64'hAA}) begin failures++; $display("FAIL rdw_new: vld=%b data=%0h expected 1 aa", v, d); end
  endtask

  task automatic test_back_to_back();
    host_rd_req = 1'b1; host_rd_addr = 4'd3;
    tick();
    checks++;
    if ({host_rd_vld, host_rd_data} !== {1'b1, 64'hFF}) begin
      failures++; $display("FAIL b2b_first: hvld=%b hdata=%0h expected 1 ff", host_rd_vld, host_rd_data);
    end
    host_rd_addr = 4'd7;
    tick();
    host_rd_req = 1'b0;
    checks++;
    if ({host_rd_vld, host_rd_data} !== {1'b1, 64'hAA}) begin
      failures++; $display("FAIL b2b_second: hvld=%b hdata=%0h expected 1 aa", host_rd_vld, host_rd_data);
    end
    tick();
    checks++;
    if (host_rd_vld !== 1'b0) begin failures++; $display("FAIL b2b_idle: hvld=%b expected 0", host_rd_vld); end
  endtask

  task automatic test_reset_mid();
    logic v; logic [63:0] d;
    req_vld = 4'hF;
    host_rd_req = 1'b1; host_rd_addr = 4'd3;
    tick();
    checks++;
    if (host_rd_vld !== 1'b1) begin failures++; $display("FAIL midrst_inflight: hvld=%b expected 1", host_rd_vld); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({host_rd_vld, host_rd_data, init_done, host_rd_rdy, req_rdy, ram_wr_en, ram_wr_addr} !==
        {1'b0, 64'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0}) begin
      failures++; $display("FAIL midrst_async: hvld=%b hdata=%0h done=%b hrdy=%b rdy=%b wr_en=%b addr=%0h expected 0 0 0 0 0000 1 0",
                           host_rd_vld, host_rd_data, init_done, host_rd_rdy, req_rdy, ram_wr_en, ram_wr_addr);
    end
    host_rd_req = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_init("midrst");
    for (int a = 0; a < 16; a++) begin
      host_read(4'(a), 1'b0, v, d);
      checks++;
      if ({v, d} !== {1'b1, 64'h0}) begin failures++; $display("FAIL midrst_read%0d: vld=%b data=%0h expected 1 0", a, v, d); end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    host_rd_req = 1'b0; host_rd_addr = 4'h0; host_rd_clr = 1'b0;
    clear_reqs();
    test_reset();
    test_round_robin();
    test_merge();
    test_clear_on_read();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sta_mirror_arb.md
# sta_mirror_arb

Write/read scheduler for the 16 x 64 link status mirror RAM (distributed simple dual-port RAM, asynchronous read, no output register). It clears the RAM after reset, shares the single write port among NUM_REQ status producers (per-lane link monitors) by round-robin, and shares the single read port between host reads and read-modify-write (sticky-OR) updates. Sits between the lane status sources and the register-bank host read path; the RAM's wr_clk and rd_clk are both tied to clk.

## Interface

- NUM_REQ, 4, number of status requesters (2..8)
- ADDR_WIDTH, 4, RAM address width
- DATA_WIDTH, 64, RAM data width

- clk  in  1  single clock for the block and both RAM clocks
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  requester i has an update pending
- req_rdy  out  NUM_REQ  one-hot grant; transfer when req_vld[i] & req_rdy[i]
- req_merge  in  NUM_REQ  1 = OR data into stored word, 0 = overwrite
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*DATA_WIDTH  packed likewise
- host_rd_req  in  1  host read request (single-cycle qualifier)
- host_rd_rdy  out  1  host read accepted when host_rd_req & host_rd_rdy
- host_rd_addr  in  ADDR_WIDTH  host read address
- host_rd_clr  in  1  clear-on-read: write 0 to host_rd_addr in the accept cycle
- host_rd_vld  out  1  host_rd_data valid
- host_rd_data  out  DATA_WIDTH  registered read data
- init_done  out  1  RAM clear complete
- ram_wr_en, ram_wr_addr, ram_wr_data  out  1/ADDR_WIDTH/DATA_WIDTH  RAM write port
- ram_rd_addr  out  ADDR_WIDTH  RAM read address
- ram_rd_data  in  DATA_WIDTH  RAM asynchronous read data

## Operation

- States: INIT, RUN. Reset -> INIT with clear counter 0.
- INIT: ram_wr_en=1, ram_wr_addr=counter, ram_wr_data=0; counter increments each cycle; on counter = 2^ADDR_WIDTH-1 -> RUN. req_rdy=0, host_rd_rdy=0. Zero writes occurring while rst_n is low are harmless by design.
- RUN: host_rd_rdy=1 always. Per cycle, in order:
  - Host accept: ram_rd_addr=host_rd_addr; host_rd_data <= ram_rd_data, host_rd_vld <= 1 next cycle. If host_rd_clr: write port writes 0 to host_rd_addr, no requester granted.
  - Otherwise ram_rd_addr = granted requester address (don't-care if none).
  - Eligibility: requester i eligible if req_vld[i] and (req_merge[i]=0 or no host read this cycle).
  - Round-robin among eligible, starting at pointer p; grant one, req_rdy combinational. ram_wr_data = req_merge ? (ram_rd_data | req_data) : req_data. Pointer <= grant+1 mod NUM_REQ; unchanged if no grant.
- Read-during-write same address, same cycle: read returns pre-write value.
- A requester deasserting req_vld without grant is legal; no state retained.
- Reset mid-operation: all state cleared asynchronously; INIT restarts at address 0; in-flight host read is lost (host_rd_vld=0).

## Timing

- Reset values: req_rdy=0, host_rd_rdy=0, host_rd_vld=0, host_rd_data=0, init_done=0, pointer=0, ram_wr_en=1 (INIT).
- INIT lasts exactly 2^ADDR_WIDTH cycles after rst_n deassertion; init_done (registered) rises on the edge completing the last write and stays 1 until reset.
- Host read latency: 1 cycle (accept at edge N, host_rd_vld=1 during cycle N+1, single cycle per accept). Back-to-back accepts give back-to-back valids.
- Write visibility: data written at edge N is returned by any read accepted at edge N+1 or later.
- Merge RMW completes in the grant cycle; zero added latency.
- Throughput: one RAM write per cycle; a requester waits at most NUM_REQ-1 grants, except merge requesters are additionally blocked by continuous host reads (accepted starvation case).

## Test plan

- Reset release -> ram_wr_en high 16 cycles, addresses 0..15, data 0; init_done rises after cycle 16; host read of addr 5 returns 0.
- All 4 req_vld held, overwrite, addresses 0..3 data 0x11..0x44 -> grants 0,1,2,3,0 in consecutive cycles; pointer wraps to 0.
- Stored 0x0F at addr 3; req_merge=1 data 0xF0 -> addr 3 reads 0xFF next cycle.
- Host read addr 2 (clr=1) while req 1 overwrite pending -> no grant that cycle, host_rd_data = old value, addr 2 reads 0 after; req 1 granted next cycle.
- Host read addr 7 concurrent with req 0 overwrite addr 7 = 0xAA -> host_rd_data = old value; following read returns 0xAA.
- rst_n pulsed low mid-RUN with host read in flight -> host_rd_vld=0 immediately, INIT restarts at address 0, all entries read 0 afterwards.
